// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants for the 16-bit pipelined CPU.
//   TAG_W / DATA_W   register-tag and datapath widths
//   TAG_SP/IH/T/NONE special register-tag encodings (4'b0xxx = general reg x)
//   producerMatch()  true when a valid, register-writing producer targets a source tag
package cpu_pkg;

  localparam int unsigned TAG_W  = 4;
  localparam int unsigned DATA_W = 16;

  localparam logic [TAG_W-1:0] TAG_SP   = 4'b1000;
  localparam logic [TAG_W-1:0] TAG_IH   = 4'b1001;
  localparam logic [TAG_W-1:0] TAG_T    = 4'b1010;
  localparam logic [TAG_W-1:0] TAG_NONE = 4'b1111;

  // A "none" source never depends on anything, whatever the producer holds.
  function automatic logic producerMatch(
    input logic             valid,
    input logic             regWrite,
    input logic [TAG_W-1:0] dstTag,
    input logic [TAG_W-1:0] srcTag
  );
    return valid & regWrite & (srcTag != TAG_NONE) & (dstTag == srcTag);
  endfunction

endpackage

// File: rtl/operand_fwd_sel.sv
// operand_fwd_sel: per-operand RAW check and operand source select.
// Optional feature macro: STAGE_FWD_EN (operand forwarding from EX/MEM).
// Ports:
//   srcTag                          source tag of the decode operand
//   rfData                          register-file read data for that operand
//   exValid/exRegWrite/exMemRead    EX-stage producer status
//   exDstTag/exAluResult            EX-stage destination tag and ALU result
//   memValid/memRegWrite/memDstTag  MEM-stage producer status
//   memResult                       MEM-stage result
//   opData_c                        combinational operand to capture into EX
//   hazard_c                        combinational: this operand cannot be captured yet
module operand_fwd_sel #(
  parameter int unsigned DATA_W = cpu_pkg::DATA_W
) (
  input  logic [cpu_pkg::TAG_W-1:0] srcTag,
  input  logic [DATA_W-1:0]         rfData,
  input  logic                      exValid,
  input  logic                      exRegWrite,
  input  logic                      exMemRead,
  input  logic [cpu_pkg::TAG_W-1:0] exDstTag,
  input  logic [DATA_W-1:0]         exAluResult,
  input  logic                      memValid,
  input  logic                      memRegWrite,
  input  logic [cpu_pkg::TAG_W-1:0] memDstTag,
  input  logic [DATA_W-1:0]         memResult,
  output logic [DATA_W-1:0]         opData_c,
  output logic                      hazard_c
);

  import cpu_pkg::*;

  logic exMatch;
  logic memMatch;

  assign exMatch  = producerMatch(exValid, exRegWrite, exDstTag, srcTag);
  assign memMatch = producerMatch(memValid, memRegWrite, memDstTag, srcTag);

`ifdef STAGE_FWD_EN
  // Youngest producer wins; a load in EX has no data yet, so it must stall one cycle.
  always_comb begin
    opData_c = rfData;
    hazard_c = 1'b0;
    if (exMatch) begin
      if (exMemRead) begin
        hazard_c = 1'b1;
      end else begin
        opData_c = exAluResult;
      end
    end else if (memMatch) begin
      opData_c = memResult;
    end
  end
`else
  // No bypass network: any in-flight producer forces a wait until it reaches WB.
  assign opData_c = rfData;
  assign hazard_c = exMatch | memMatch;

  logic unusedFwdInputs;
  assign unusedFwdInputs = ^{exMemRead, exAluResult, memResult};
`endif

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with RAW hazard detection.
// Optional feature macro: STAGE_FWD_EN (forward EX/MEM results at capture;
// only load-use then stalls).
// Ports:
//   CLK, RST                    clock, synchronous active-high reset
//   id_*                        decode-stage instruction fields and tags
//   ex_flush                    taken branch/jump: kill the decode instruction
//   ex_stall                    downstream busy: hold EX contents
//   ex_alu_result               EX combinational result (forwarding source)
//   mem_valid/reg_write/dst_tag MEM-stage producer status
//   mem_result                  MEM result (forwarding source)
//   ex_*                        registered EX-stage fields
//   stall_req                   combinational: IF and ID must hold this cycle
module id_ex_stage #(
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned DATA_W = cpu_pkg::DATA_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [DATA_W-1:0] id_op1,
  input  logic [DATA_W-1:0] id_op2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_mem_read,
  input  logic              id_reg_write,
  input  logic [3:0]        id_dst_tag,
  input  logic [3:0]        id_src1_tag,
  input  logic [3:0]        id_src2_tag,
  input  logic              ex_flush,
  input  logic              ex_stall,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic              mem_valid,
  input  logic              mem_reg_write,
  input  logic [3:0]        mem_dst_tag,
  input  logic [DATA_W-1:0] mem_result,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_op1,
  output logic [DATA_W-1:0] ex_op2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_mem_read,
  output logic              ex_reg_write,
  output logic [3:0]        ex_dst_tag,
  output logic [3:0]        ex_src1_tag,
  output logic [3:0]        ex_src2_tag,
  output logic              stall_req
);

  import cpu_pkg::*;

  logic [DATA_W-1:0] op1Sel;
  logic [DATA_W-1:0] op2Sel;
  logic              op1Haz;
  logic              op2Haz;
  logic              haz;

  // Operand 1 dependency check and source select
  operand_fwd_sel #(.DATA_W(DATA_W)) op1Fwd (
    .srcTag      (id_src1_tag),
    .rfData      (id_op1),
    .exValid     (ex_valid),
    .exRegWrite  (ex_reg_write),
    .exMemRead   (ex_mem_read),
    .exDstTag    (ex_dst_tag),
    .exAluResult (ex_alu_result),
    .memValid    (mem_valid),
    .memRegWrite (mem_reg_write),
    .memDstTag   (mem_dst_tag),
    .memResult   (mem_result),
    .opData_c    (op1Sel),
    .hazard_c    (op1Haz)
  );

  // Operand 2 dependency check and source select
  operand_fwd_sel #(.DATA_W(DATA_W)) op2Fwd (
    .srcTag      (id_src2_tag),
    .rfData      (id_op2),
    .exValid     (ex_valid),
    .exRegWrite  (ex_reg_write),
    .exMemRead   (ex_mem_read),
    .exDstTag    (ex_dst_tag),
    .exAluResult (ex_alu_result),
    .memValid    (mem_valid),
    .memRegWrite (mem_reg_write),
    .memDstTag   (mem_dst_tag),
    .memResult   (mem_result),
    .opData_c    (op2Sel),
    .hazard_c    (op2Haz)
  );

  // A flushed or empty decode slot cannot create a dependency.
  assign haz       = id_valid & ~ex_flush & (op1Haz | op2Haz);
  assign stall_req = haz | ex_stall;

  // EX register: reset > flush > downstream stall > hazard bubble > capture
  always_ff @(posedge CLK) begin
    if (RST || ex_flush || (!ex_stall && haz)) begin
      // Reset state and bubble are the same empty slot.
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_op1       <= '0;
      ex_op2       <= '0;
      ex_imm       <= '0;
      ex_ctrl      <= '0;
      ex_mem_read  <= 1'b0;
      ex_reg_write <= 1'b0;
      ex_dst_tag   <= TAG_NONE;
      ex_src1_tag  <= TAG_NONE;
      ex_src2_tag  <= TAG_NONE;
    end else if (!ex_stall) begin
      ex_valid     <= id_valid;
      ex_pc        <= id_pc;
      ex_op1       <= op1Sel;
      ex_op2       <= op2Sel;
      ex_imm       <= id_imm;
      ex_ctrl      <= id_ctrl;
      // An invalid slot must never look like a producer downstream.
      ex_mem_read  <= id_valid & id_mem_read;
      ex_reg_write <= id_valid & id_reg_write;
      ex_dst_tag   <= id_dst_tag;
      ex_src1_tag  <= id_src1_tag;
      ex_src2_tag  <= id_src2_tag;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed test-plan scenarios followed by randomized traffic,
// checked against a behavioural model of the ID/EX slot. The MEM-stage inputs
// follow the model's EX slot whenever downstream is not stalled.
module tb_id_ex_stage;

  import cpu_pkg::*;

  logic        CLK;
  logic        RST;
  logic        id_valid;
  logic [15:0] id_pc, id_op1, id_op2, id_imm;
  logic [7:0]  id_ctrl;
  logic        id_mem_read, id_reg_write;
  logic [3:0]  id_dst_tag, id_src1_tag, id_src2_tag;
  logic        ex_flush, ex_stall;
  logic [15:0] ex_alu_result;
  logic        mem_valid, mem_reg_write;
  logic [3:0]  mem_dst_tag;
  logic [15:0] mem_result;
  logic        ex_valid;
  logic [15:0] ex_pc, ex_op1, ex_op2, ex_imm;
  logic [7:0]  ex_ctrl;
  logic        ex_mem_read, ex_reg_write;
  logic [3:0]  ex_dst_tag, ex_src1_tag, ex_src2_tag;
  logic        stall_req;

  id_ex_stage dut (
    .CLK(CLK), .RST(RST),
    .id_valid(id_valid), .id_pc(id_pc), .id_op1(id_op1), .id_op2(id_op2),
    .id_imm(id_imm), .id_ctrl(id_ctrl), .id_mem_read(id_mem_read),
    .id_reg_write(id_reg_write), .id_dst_tag(id_dst_tag),
    .id_src1_tag(id_src1_tag), .id_src2_tag(id_src2_tag),
    .ex_flush(ex_flush), .ex_stall(ex_stall), .ex_alu_result(ex_alu_result),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write),
    .mem_dst_tag(mem_dst_tag), .mem_result(mem_result),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op1(ex_op1), .ex_op2(ex_op2),
    .ex_imm(ex_imm), .ex_ctrl(ex_ctrl), .ex_mem_read(ex_mem_read),
    .ex_reg_write(ex_reg_write), .ex_dst_tag(ex_dst_tag),
    .ex_src1_tag(ex_src1_tag), .ex_src2_tag(ex_src2_tag),
    .stall_req(stall_req)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        valid;
    logic [15:0] pc, op1, op2, imm;
    logic [7:0]  ctrl;
    logic        memRead, regWrite;
    logic [3:0]  dst, s1, s2;
  } exSlot_t;

  exSlot_t model;
  int      nCompared = 0;
  int      nMismatched = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exSlot_t emptySlot();
    exSlot_t s;
    s       = '0;
    s.dst   = TAG_NONE;
    s.s1    = TAG_NONE;
    s.s2    = TAG_NONE;
    return s;
  endfunction

  function automatic logic writes(input logic v, input logic rw, input logic [3:0] dst,
                                  input logic [3:0] src);
    return (src != TAG_NONE) && v && rw && (dst == src);
  endfunction

  function automatic logic srcBlocked(input logic [3:0] src);
    logic inEx, inMem;
    inEx  = writes(model.valid, model.regWrite, model.dst, src);
    inMem = writes(mem_valid, mem_reg_write, mem_dst_tag, src);
`ifdef STAGE_FWD_EN
    return inEx && model.memRead;
`else
    return inEx || inMem;
`endif
  endfunction

  function automatic logic [15:0] srcValue(input logic [3:0] src, input logic [15:0] rf);
`ifdef STAGE_FWD_EN
    if (writes(model.valid, model.regWrite, model.dst, src)) return ex_alu_result;
    if (writes(mem_valid, mem_reg_write, mem_dst_tag, src)) return mem_result;
`endif
    return rf;
  endfunction

  function automatic logic modelHaz();
    return id_valid && !ex_flush && (srcBlocked(id_src1_tag) || srcBlocked(id_src2_tag));
  endfunction

  // One clock: check stall_req mid-cycle, advance model, check all EX outputs.
  task automatic step();
    exSlot_t nxt, prev;
    logic    expStall;
    @(negedge CLK);
    expStall = modelHaz() || ex_stall;
    checkVal("stall_req", 32'(stall_req), 32'(expStall));
    if (RST || ex_flush) nxt = emptySlot();
    else if (ex_stall) nxt = model;
    else if (modelHaz()) nxt = emptySlot();
    else begin
      nxt.valid    = id_valid;
      nxt.pc       = id_pc;
      nxt.op1      = srcValue(id_src1_tag, id_op1);
      nxt.op2      = srcValue(id_src2_tag, id_op2);
      nxt.imm      = id_imm;
      nxt.ctrl     = id_ctrl;
      nxt.memRead  = id_valid && id_mem_read;
      nxt.regWrite = id_valid && id_reg_write;
      nxt.dst      = id_dst_tag;
      nxt.s1       = id_src1_tag;
      nxt.s2       = id_src2_tag;
    end
    prev = model;
    @(posedge CLK);
    #1;
    model = nxt;
    checkVal("ex_valid",     32'(ex_valid),     32'(model.valid));
    checkVal("ex_pc",        32'(ex_pc),        32'(model.pc));
    checkVal("ex_op1",       32'(ex_op1),       32'(model.op1));
    checkVal("ex_op2",       32'(ex_op2),       32'(model.op2));
    checkVal("ex_imm",       32'(ex_imm),       32'(model.imm));
    checkVal("ex_ctrl",      32'(ex_ctrl),      32'(model.ctrl));
    checkVal("ex_mem_read",  32'(ex_mem_read),  32'(model.memRead));
    checkVal("ex_reg_write", 32'(ex_reg_write), 32'(model.regWrite));
    checkVal("ex_dst_tag",   32'(ex_dst_tag),   32'(model.dst));
    checkVal("ex_src1_tag",  32'(ex_src1_tag),  32'(model.s1));
    checkVal("ex_src2_tag",  32'(ex_src2_tag),  32'(model.s2));
    if (RST) begin
      mem_valid = 1'b0; mem_reg_write = 1'b0; mem_dst_tag = TAG_NONE;
    end else if (!ex_stall) begin
      mem_valid     = prev.valid;
      mem_reg_write = prev.regWrite;
      mem_dst_tag   = prev.dst;
      mem_result    = 16'($urandom);
    end
  endtask

  task automatic peekStall(input string tag, input logic exp);
    #1;
    checkVal(tag, 32'(stall_req), 32'(exp));
  endtask

  task automatic setId(input logic v, input logic [15:0] pc, input logic [15:0] op1,
                       input logic [15:0] op2, input logic [3:0] dst, input logic [3:0] s1,
                       input logic [3:0] s2, input logic memRd, input logic regWr);
    id_valid = v; id_pc = pc; id_op1 = op1; id_op2 = op2;
    id_imm = pc ^ 16'h5A5A; id_ctrl = pc[7:0] ^ 8'hC3;
    id_dst_tag = dst; id_src1_tag = s1; id_src2_tag = s2;
    id_mem_read = memRd; id_reg_write = regWr;
  endtask

  logic [3:0] tagSet [7];
  int         bubbles;

  initial begin
    tagSet = '{4'h0, 4'h1, 4'h2, 4'h3, TAG_SP, TAG_IH, TAG_NONE};
    model  = emptySlot();
    setId(1'b0, 16'h0, 16'h0, 16'h0, TAG_NONE, TAG_NONE, TAG_NONE, 1'b0, 1'b0);
    RST = 1'b1; ex_flush = 1'b0; ex_stall = 1'b0; ex_alu_result = 16'h0;
    mem_valid = 1'b0; mem_reg_write = 1'b0; mem_dst_tag = TAG_NONE; mem_result = 16'h0;

    // Reset
    step(); step();
    checkVal("reset_valid", 32'(ex_valid), 32'd0);
    checkVal("reset_pc", 32'(ex_pc), 32'd0);
    checkVal("reset_tags", 32'({ex_dst_tag, ex_src1_tag, ex_src2_tag}), 32'h0FFF);
    peekStall("reset_stall_req", 1'b0);
    RST = 1'b0;

    // Clean flow
    setId(1'b1, 16'h0010, 16'h1234, 16'h4321, 4'h5, 4'h1, 4'h2, 1'b0, 1'b1);
    step();
    checkVal("clean_pc", 32'(ex_pc), 32'h0010);
    checkVal("clean_op1", 32'(ex_op1), 32'h1234);
    checkVal("clean_valid", 32'(ex_valid), 32'd1);

    // Load-use
    setId(1'b1, 16'h0020, 16'h0, 16'h0, 4'h3, TAG_NONE, TAG_NONE, 1'b1, 1'b1);
    step();
    setId(1'b1, 16'h0022, 16'h1111, 16'h2222, 4'h6, 4'h3, TAG_NONE, 1'b0, 1'b1);
    peekStall("lu_stall_req", 1'b1);
    step();
    checkVal("lu_bubble", 32'(ex_valid), 32'd0);
    mem_result = 16'hBEEF;
`ifdef STAGE_FWD_EN
    peekStall("lu_released", 1'b0);
    step();
    checkVal("lu_fwd_op1", 32'(ex_op1), 32'hBEEF);
`else
    peekStall("lu_mem_stall", 1'b1);
    step();
    checkVal("lu_bubble2", 32'(ex_valid), 32'd0);
    peekStall("lu_released", 1'b0);
    step();
    checkVal("lu_rf_op1", 32'(ex_op1), 32'h1111);
`endif
    checkVal("lu_pc", 32'(ex_pc), 32'h0022);

    // ALU RAW on SP
    setId(1'b1, 16'h0030, 16'h0, 16'h0, TAG_SP, TAG_NONE, TAG_NONE, 1'b0, 1'b1);
    step();
    setId(1'b1, 16'h0032, 16'h1111, 16'h2222, 4'h7, TAG_NONE, TAG_SP, 1'b0, 1'b1);
    ex_alu_result = 16'h7FF0;
    bubbles = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (!stall_req) break;
      bubbles++;
      step();
    end
    step();
`ifdef STAGE_FWD_EN
    checkVal("alu_raw_bubbles", 32'(bubbles), 32'd0);
    checkVal("alu_raw_op2", 32'(ex_op2), 32'h7FF0);
`else
    checkVal("alu_raw_bubbles", 32'(bubbles), 32'd2);
    checkVal("alu_raw_op2", 32'(ex_op2), 32'h2222);
`endif

    // Flush during hazard
    setId(1'b1, 16'h0040, 16'h0, 16'h0, 4'h3, TAG_NONE, TAG_NONE, 1'b1, 1'b1);
    step();
    setId(1'b1, 16'h0042, 16'h3333, 16'h4444, 4'h4, 4'h3, TAG_NONE, 1'b0, 1'b1);
    ex_flush = 1'b1;
    peekStall("flush_stall_req", 1'b0);
    step();
    checkVal("flush_valid", 32'(ex_valid), 32'd0);
    checkVal("flush_src1", 32'(ex_src1_tag), 32'hF);
    ex_flush = 1'b0;
    setId(1'b0, 16'h0044, 16'h0, 16'h0, TAG_NONE, TAG_NONE, TAG_NONE, 1'b0, 1'b0);
    step();
    checkVal("flush_dropped", 32'(ex_valid), 32'd0);

    // Downstream stall
    setId(1'b1, 16'h0050, 16'hAAAA, 16'hBBBB, 4'h1, TAG_NONE, TAG_NONE, 1'b0, 1'b1);
    step();
    setId(1'b1, 16'h0060, 16'hCCCC, 16'hDDDD, 4'h2, TAG_NONE, TAG_NONE, 1'b0, 1'b1);
    ex_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      peekStall("ds_stall_req", 1'b1);
      step();
      checkVal("ds_hold_pc", 32'(ex_pc), 32'h0050);
    end
    ex_stall = 1'b0;
    step();
    checkVal("ds_release_pc", 32'(ex_pc), 32'h0060);

    // Reset while stalled
    ex_stall = 1'b1; RST = 1'b1;
    step();
    checkVal("rst_stall_valid", 32'(ex_valid), 32'd0);
    checkVal("rst_stall_pc", 32'(ex_pc), 32'd0);
    RST = 1'b0; ex_stall = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      RST      = ($urandom_range(0, 63) == 0);
      ex_flush = ($urandom_range(0, 9) == 0);
      ex_stall = ($urandom_range(0, 5) == 0);
      ex_alu_result = 16'($urandom);
      setId($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom), 16'($urandom),
            tagSet[$urandom_range(0, 6)], tagSet[$urandom_range(0, 6)],
            tagSet[$urandom_range(0, 6)], 1'($urandom), 1'($urandom));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
